// File: rtl/cart_seq_pkg.sv
// Shared types and default timing for the cartridge bus sequencer.
package cart_seq_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    HOLD
  } cart_seq_state_t;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } cart_req_t;

  localparam int DEF_SETUP_CYCLES  = 2;
  localparam int DEF_ACCESS_CYCLES = 4;
  localparam int DEF_HOLD_CYCLES   = 1;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/cart_rd_sync.sv
// Two-flop 8-bit register stage on the cartridge read-data path.
module cart_rd_sync (
  input  logic       clk,
  input  logic       n_rst,
  input  logic [7:0] d_in,
  output logic [7:0] q_out
);

  logic [7:0] s1_q, s1_d;
  logic [7:0] s2_q, s2_d;

  always_comb begin
    s1_d = d_in;
    s2_d = s1_q;
  end

  // NOTE: sequential state uses <= so every flop samples the pre-edge values.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
    end
  end

  assign q_out = s2_q;

endmodule

// File: rtl/cart_bus_sequencer.sv
// Turns single-byte requests into timed cartridge bus cycles (setup/access/hold).
// Define CART_SEQ_RDSYNC_EN to register read data through two flops before capture.
module cart_bus_sequencer
  import cart_seq_pkg::*;
#(
  parameter int SETUP_CYCLES  = DEF_SETUP_CYCLES,
  parameter int ACCESS_CYCLES = DEF_ACCESS_CYCLES,
  parameter int HOLD_CYCLES   = DEF_HOLD_CYCLES
) (
  input  logic        clk,
  input  logic        n_rst,
  input  logic        req_in,
  input  logic        we_in,
  input  logic [15:0] addr_in,
  input  logic [7:0]  wdata_in,
  output logic        ready_out,
  output logic        done_out,
  output logic [7:0]  rdata_out,
  output logic [15:0] cart_addr_out,
  output logic        cart_we_out,
  output logic [7:0]  cart_wdata_out,
  input  logic [7:0]  cart_rdata_in
);

`ifdef CART_SEQ_RDSYNC_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 0;
`endif

  // The access window is stretched by the read-path latency so capture sees the synced byte.
  localparam int ACC_LEN = ACCESS_CYCLES + RD_LAT;
  localparam int CNT_W   = $clog2(max3(SETUP_CYCLES, ACC_LEN, HOLD_CYCLES) + 1);

  localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACC_LOAD   = CNT_W'(ACC_LEN - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'(HOLD_CYCLES - 1);

  if (SETUP_CYCLES < 1) begin : g_bad_setup
    $error("cart_bus_sequencer: SETUP_CYCLES must be >= 1");
  end
  if (ACCESS_CYCLES < 1) begin : g_bad_access
    $error("cart_bus_sequencer: ACCESS_CYCLES must be >= 1");
  end
  if (HOLD_CYCLES < 1) begin : g_bad_hold
    $error("cart_bus_sequencer: HOLD_CYCLES must be >= 1");
  end

  cart_seq_state_t  state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  cart_req_t        req_q, req_d;
  logic [7:0]       rdata_q, rdata_d;
  logic [7:0]       rd_sample;
  logic             ready_q, ready_d;
  logic             done_q, done_d;
  logic             cart_we_q, cart_we_d;
  logic             we_window;

`ifdef CART_SEQ_RDSYNC_EN
  cart_rd_sync u_rd_sync (
    .clk   (clk),
    .n_rst (n_rst),
    .d_in  (cart_rdata_in),
    .q_out (rd_sample)
  );
  // Strobe covers only the first ACCESS_CYCLES cycles; the tail waits for synced data.
  assign we_window = (cnt_d >= CNT_W'(RD_LAT));
`else
  assign rd_sample = cart_rdata_in;
  assign we_window = 1'b1;
`endif

  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    done_d  = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (req_in) begin
          req_d   = '{we: we_in, addr: addr_in, wdata: wdata_in};
          state_d = SETUP;
          cnt_d   = SETUP_LOAD;
        end
      end
      SETUP: begin
        if (cnt_q == '0) begin
          state_d = ACCESS;
          cnt_d   = ACC_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      ACCESS: begin
        if (cnt_q == '0) begin
          if (!req_q.we) rdata_d = rd_sample;
          state_d = HOLD;
          cnt_d   = HOLD_LOAD;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    ready_d   = (state_d == IDLE);
    cart_we_d = req_q.we && (state_d == ACCESS) && we_window;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      req_q     <= '0;
      rdata_q   <= '0;
      ready_q   <= 1'b1;
      done_q    <= 1'b0;
      cart_we_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      req_q     <= req_d;
      rdata_q   <= rdata_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      cart_we_q <= cart_we_d;
    end
  end

  assign ready_out      = ready_q;
  assign done_out       = done_q;
  assign rdata_out      = rdata_q;
  assign cart_addr_out  = req_q.addr;
  assign cart_we_out    = cart_we_q;
  assign cart_wdata_out = req_q.wdata;

endmodule

// File: doc/cart_bus_sequencer.md
# cart_bus_sequencer

- Sits directly upstream of the cartridge pin interface.
- Accepts single-byte read/write requests from the memory map with a valid/ready handshake.
- Turns each request into a timed cartridge bus cycle: address setup, access window, hold.
- Drives the cartridge-side memory interface fields (address select, write enable, write value), samples the returned read byte, and reports completion with a one-cycle pulse.

## Interface
- SETUP_CYCLES, 2: cycles address is stable before the access window; legal range ≥1.
- ACCESS_CYCLES, 4: cycles in the access window; write strobe width; read sampled on its last cycle; legal range ≥1.
- HOLD_CYCLES, 1: cycles address and data are held after the access window; legal range ≥1.
- clk  input  1  system clock.
- n_rst  input  1  reset, asynchronous, active-low.
- req_in  input  1  request valid.
- we_in  input  1  1 = write, 0 = read.
- addr_in  input  16  request address.
- wdata_in  input  8  write byte.
- ready_out  output  1  sequencer can accept a request.
- done_out  output  1  one-cycle completion pulse.
- rdata_out  output  8  last read byte.
- cart_addr_out  output  16  to addr_select.
- cart_we_out  output  1  to write_enable.
- cart_wdata_out  output  8  to write_value.
- cart_rdata_in  input  8  from read_out.

## Operation
- FSM states: IDLE, SETUP, ACCESS, HOLD. One down-counter is loaded on each state entry.
- IDLE
  - ready_out=1.
  - On req_in && ready_out: latch addr_in, we_in and wdata_in into cart_addr_out, an internal we flag and cart_wdata_out.
  - Load counter with SETUP_CYCLES-1 and go to SETUP.
- SETUP: count down to 0, then load ACCESS_CYCLES-1 and go to ACCESS.
- ACCESS
  - cart_we_out = latched we flag (registered; high for exactly ACCESS_CYCLES cycles on writes, never on reads).
  - On the last ACCESS cycle of a read, capture cart_rdata_in into rdata_out.
  - Then load HOLD_CYCLES-1 and go to HOLD.
- HOLD
  - cart_we_out=0. Address and write data stay unchanged.
  - At count 0 go to IDLE and assert done_out for that IDLE cycle.
- Non-IDLE states: ready_out=0. req_in is ignored (no queueing).
- cart_addr_out and cart_wdata_out keep their last value in IDLE.
- rdata_out holds until the next read capture. A write does not change rdata_out.
- Counter width: $clog2(max(SETUP,ACCESS,HOLD)+1). Parameters <1 trigger an elaboration $error.

## Timing
- Request accepted at clock edge t0.
- SETUP occupies S cycles, ACCESS A cycles, HOLD H cycles.
- done_out is high in the cycle starting at edge t0+S+A+H. With defaults that is 7 cycles.
- ready_out is high in that same cycle, so back-to-back requests have a zero-cycle gap.
- done_out and a new accept may coincide.
- Reset values: ready_out=1, done_out=0, rdata_out=0, cart_addr_out=0, cart_we_out=0, cart_wdata_out=0, state IDLE.
- Reset asserted mid-cycle:
  - All outputs take their reset values immediately (asynchronously). cart_we_out drops without waiting for a clock.
  - No done_out is issued for the aborted request.
- Reset deassertion is synchronised externally. The first edge after release may accept a request.

## Configuration
- CART_SEQ_RDSYNC_EN defined:
  - cart_rdata_in passes through a two-flop register stage before capture.
  - ACCESS lasts ACCESS_CYCLES+2 cycles; the write strobe is still exactly ACCESS_CYCLES cycles, asserted from ACCESS entry.
  - The read capture uses the registered value on the last ACCESS cycle.
  - Total latency is S+A+H+2 for reads and writes.
- Undefined: direct sampling as described above; latency S+A+H.

## Structure
- cart_seq_pkg:
  - cart_seq_state_t enum (IDLE, SETUP, ACCESS, HOLD).
  - cart_req_t packed struct {we, addr[15:0], wdata[7:0]}.
  - Default timing localparams.
- One sub-module, cart_rd_sync: two-flop 8-bit register stage with async active-low reset to 0. Instantiated only under CART_SEQ_RDSYNC_EN.

## Test plan
- Reset with n_rst=0 mid-ACCESS of a write:
  - cart_we_out goes 0 before the next edge.
  - ready_out=1, no done_out.
- Read 0x0150, cart_rdata_in=0xC3 during ACCESS:
  - done_out exactly 7 cycles after accept.
  - rdata_out=0xC3; cart_we_out never 1.
- Write 0x2000←0x01:
  - cart_addr_out=0x2000 for all 7 busy cycles; cart_wdata_out=0x01.
  - cart_we_out high exactly 4 cycles, starting 2 cycles after accept.
- Back-to-back read 0x4000 then write 0x0000←0xFF with req_in held high:
  - second accept on the done_out cycle.
  - rdata_out unchanged by the write.
- req_in pulsed during SETUP/HOLD of an in-flight request: ignored, single done_out.
- SETUP=1, ACCESS=1, HOLD=1 with CART_SEQ_RDSYNC_EN:
  - read latency 5.
  - rdata equals the value presented two cycles before capture.
